mac_operand_sequencer: RTL and testbench
========================================

# mac_operand_sequencer

Upstream control stage for the accumulating multiply unit (`MAC`, 8-bit operands, 24-bit accumulator with `En`/`Clr`). It accepts a job command with a vector length and consumes paired A/B operand streams over valid/ready handshakes. It drives the MAC's clear, enable and operand inputs, then presents the finished dot product on a valid/ready result port. It lets one MAC compute length-N dot products without software pacing each element.

## Interface
- `DATA_WIDTH`, 8: operand width; the result is `3*DATA_WIDTH` bits.
- `LEN_WIDTH`, 8: width of the job length; max length is `2^LEN_WIDTH-1`.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset. One clock; reset is asynchronous and active-high.
- `start` in 1: job request; sampled only in IDLE.
- `len` in LEN_WIDTH: number of operand pairs; sampled with `start`.
- `busy` out 1: high whenever state ≠ IDLE.
- `a_valid` in 1, `a_data` in DATA_WIDTH, `a_ready` out 1: A operand stream.
- `b_valid` in 1, `b_data` in DATA_WIDTH, `b_ready` out 1: B operand stream.
- `mac_clr` out 1, `mac_en` out 1, `mac_ain` out DATA_WIDTH, `mac_bin` out DATA_WIDTH: drive the MAC's Clr/En/Ain/Bin.
- `mac_cout` in 3*DATA_WIDTH: MAC accumulator output.
- `res_valid` out 1, `res_data` out 3*DATA_WIDTH, `res_ready` in 1: result stream.

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, DONE.
- **IDLE**
  - `start=1` → CLEAR; latch `len` into the `remaining` counter.
  - `start` is ignored in every other state.
- **CLEAR**
  - `mac_clr=1` for exactly this cycle.
  - Next state is RUN if `remaining≠0`, otherwise DONE.
- **RUN**
  - Joint handshake: `a_ready = b_ready = a_valid & b_valid` (in RUN only). Neither stream is consumed alone.
  - fire = `a_valid & b_valid` in RUN.
  - On fire:
    - `mac_ain`/`mac_bin` registers capture `a_data`/`b_data`.
    - The `mac_en` flop is set for the next cycle.
    - `remaining` decrements.
  - When the fire consumes the last pair (`remaining==1`) → DRAIN.
- **DRAIN**
  - One cycle; the last `mac_en` is high here.
  - → DONE.
- **DONE**
  - `res_valid=1`; `res_data=mac_cout` (combinational; the MAC holds its value since `mac_en=0`).
  - `res_valid & res_ready` → IDLE.
- **Outputs and arithmetic**
  - `mac_en` is a flop, high only in the cycle after a fire; it is low at all other times.
  - `mac_ain`/`mac_bin` hold their last value when not enabled.
  - `mac_clr` is decoded from the state register (CLEAR only).
  - Accumulation wraps modulo `2^(3*DATA_WIDTH)`; the sequencer does no overflow handling.
- **Boundaries**
  - `len=0`: no operand is consumed; the result is 0.
  - Operand valids may drop at any time in RUN; the sequencer stalls with no `mac_en`.
  - Result backpressure: DONE holds indefinitely and `res_data` stays stable. `start` during DONE is ignored.
  - Reset mid-job: the block returns to IDLE at once and drops the job. A stale MAC value is cleared by the next job's CLEAR.

## Timing
- Reset values:
  - state IDLE, `remaining=0`.
  - `busy`, `a_ready`, `b_ready`, `mac_clr`, `mac_en`, `res_valid` all 0.
  - `mac_ain`, `mac_bin` = 0.
- Job start:
  - `start` at cycle s → CLEAR at s+1.
  - RUN at s+2, the earliest fire.
- Per pair: fire at t → `mac_en` high at t+1 → `mac_cout` includes the product from t+2.
- Throughput: one pair per cycle with both streams continuously valid.
- Last pair:
  - last fire at t → DRAIN at t+1.
  - DONE at t+2 with `res_valid=1` and the final sum.
- `len=0`: start at s → `res_valid` at s+2 with `res_data=0`.
- Result handshake: on a `res_valid & res_ready` edge the block is IDLE next cycle. A new `start` is accepted from that cycle.

## Configuration
- Macro `MAC_SEQ_ABORT_EN`. When defined:
  - Adds input `abort` (1 bit).
  - `abort=1` in CLEAR, RUN or DRAIN → CLEAR_ABORT: a one-cycle `mac_clr` pulse, then IDLE.
  - No result is produced. A pending `mac_en` is suppressed; no further pairs are consumed.
  - `abort` is ignored in IDLE and DONE.
- When undefined: no `abort` port; jobs always run to DONE.

## Test plan
- **Back-to-back job:** len=3, pairs (1,2),(3,4),(5,6) continuously valid.
  - `mac_en` high 3 consecutive cycles.
  - `res_valid` 2 cycles after the last fire; `res_data=44`.
- **Empty job:** len=0.
  - No `a_ready`/`b_ready`.
  - `res_valid` at start+2 with `res_data=0`.
- **Misaligned streams:** len=2, pairs (10,10),(2,3); `b_valid` lags `a_valid` by 3 cycles on each pair.
  - No ready until both valid; A is never consumed alone.
  - `res_data=106`.
- **Result backpressure:** len=1, (255,255); `res_ready` held low 5 cycles and `start` pulsed meanwhile.
  - `res_valid` and `res_data=65025` stay stable; the start is ignored; `busy=1`.
  - With `res_ready=1`: IDLE next cycle.
- **Reset mid-job:** `rst` after 2 of 4 pairs.
  - All outputs 0 while reset is asserted.
  - Then a new job len=1, (7,7) → `res_data=49`.
- **Abort (`MAC_SEQ_ABORT_EN`):** `abort` in RUN after 1 of 3 pairs.
  - One `mac_clr` pulse, then IDLE, no `res_valid`.
  - A following job len=1, (3,3) → 9.

Source files
------------

// File: rtl/mac_operand_sequencer.sv
// Paces paired A/B operand streams into one accumulating MAC and returns the dot product.
// Optional job abort is compiled in with `define MAC_SEQ_ABORT_EN.
module mac_operand_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    len,
    output logic                    busy,
`ifdef MAC_SEQ_ABORT_EN
    input  logic                    abort,
`endif
    input  logic                    a_valid,
    input  logic [DATA_WIDTH-1:0]   a_data,
    output logic                    a_ready,
    input  logic                    b_valid,
    input  logic [DATA_WIDTH-1:0]   b_data,
    output logic                    b_ready,
    output logic                    mac_clr,
    output logic                    mac_en,
    output logic [DATA_WIDTH-1:0]   mac_ain,
    output logic [DATA_WIDTH-1:0]   mac_bin,
    input  logic [3*DATA_WIDTH-1:0] mac_cout,
    output logic                    res_valid,
    output logic [3*DATA_WIDTH-1:0] res_data,
    input  logic                    res_ready
);

    // ST_CLEAR_ABORT is only reachable when the abort feature is built in.
    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_CLEAR       = 3'd1,
        ST_RUN         = 3'd2,
        ST_DRAIN       = 3'd3,
        ST_DONE        = 3'd4,
        ST_CLEAR_ABORT = 3'd5
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;
    logic [LEN_WIDTH-1:0]   remaining_reg;
    logic [LEN_WIDTH-1:0]   remaining_next;
    logic                   mac_en_reg;
    logic                   fire;
    logic                   abort_hit;
    logic [DATA_WIDTH-1:0]  opnd_in [2];

`ifdef MAC_SEQ_ABORT_EN
    assign abort_hit = abort & ((state_reg == ST_CLEAR) ||
                                (state_reg == ST_RUN)   ||
                                (state_reg == ST_DRAIN));
`else
    assign abort_hit = 1'b0;
`endif

    // A pair is taken only when both streams offer one; an abort blocks the take.
    assign fire = (state_reg == ST_RUN) & a_valid & b_valid & ~abort_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            remaining_reg <= '0;
            mac_en_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            mac_en_reg    <= fire;
        end
    end

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next     = ST_CLEAR;
                    remaining_next = len;
                end
            end
            ST_CLEAR: begin
                state_next = (remaining_reg != '0) ? ST_RUN : ST_DONE;
            end
            ST_RUN: begin
                if (fire) begin
                    remaining_next = remaining_reg - LEN_WIDTH'(1);
                    if (remaining_reg == LEN_WIDTH'(1)) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                state_next = ST_DONE;
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_next = ST_IDLE;
                end
            end
            ST_CLEAR_ABORT: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (abort_hit) begin
            state_next     = ST_CLEAR_ABORT;
            remaining_next = '0;
        end
    end

    assign opnd_in[0] = a_data;
    assign opnd_in[1] = b_data;

    // Operand holding registers: lane 0 feeds Ain, lane 1 feeds Bin.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_opnd
            logic [DATA_WIDTH-1:0] q_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_reg <= '0;
                end else if (fire) begin
                    q_reg <= opnd_in[gi];
                end
            end
        end
    endgenerate

    assign mac_ain   = g_opnd[0].q_reg;
    assign mac_bin   = g_opnd[1].q_reg;
    assign mac_en    = mac_en_reg;
    assign mac_clr   = (state_reg == ST_CLEAR) || (state_reg == ST_CLEAR_ABORT);
    assign busy      = (state_reg != ST_IDLE);
    assign a_ready   = fire;
    assign b_ready   = fire;
    assign res_valid = (state_reg == ST_DONE);
    // The MAC is idle in DONE, so its output is stable without a result register.
    assign res_data  = mac_cout;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Scoreboard bench for mac_operand_sequencer with a behavioural MAC and random operand streams.
// Exercises the abort path as well when built with MAC_SEQ_ABORT_EN.
module tb_mac_operand_sequencer;
    localparam int DW = 8;
    localparam int LW = 8;
    localparam int AW = 3 * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] len;
    logic          busy;
    logic          a_valid, a_ready, b_valid, b_ready;
    logic [DW-1:0] a_data, b_data;
    logic          mac_clr, mac_en;
    logic [DW-1:0] mac_ain, mac_bin;
    logic [AW-1:0] mac_cout;
    logic          res_valid, res_ready;
    logic [AW-1:0] res_data;
`ifdef MAC_SEQ_ABORT_EN
    logic          abort;
`endif

    always #5 clk = ~clk;

    mac_operand_sequencer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
`ifdef MAC_SEQ_ABORT_EN
        .abort(abort),
`endif
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .mac_clr(mac_clr), .mac_en(mac_en), .mac_ain(mac_ain), .mac_bin(mac_bin),
        .mac_cout(mac_cout),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
    );

    // Behavioural accumulating MAC: not reset, so a stale sum survives until the next clear.
    logic [AW-1:0] acc = '0;
    always @(posedge clk) begin
        if (mac_clr)     acc <= '0;
        else if (mac_en) acc <= acc + AW'(mac_ain) * AW'(mac_bin);
    end
    assign mac_cout = acc;

    typedef struct { int unsigned len; logic [AW-1:0] sum; } exp_t;
    exp_t          exp_q[$];
    logic [DW-1:0] a_q[$], b_q[$], job_a[$], job_b[$];
    int unsigned   compared = 0, mismatched = 0;
    int unsigned   jobs_issued = 0, results_seen = 0;
    int unsigned   a_gap_max = 0, b_gap_max = 0, b_lag = 0, rr_mode = 1;
    bit            flush = 1'b0;
    int unsigned   cyc = 0;
    int unsigned   fires = 0, last_fire_cyc = 0, clr_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    initial begin : drv_a
        logic [DW-1:0] item;
        int unsigned   gap;
        a_valid = 1'b0;
        a_data  = '0;
        forever begin
            if (a_q.size() == 0 || flush) begin
                a_valid = 1'b0;
                @(posedge clk); #1;
            end else begin
                item = a_q.pop_front();
                gap  = $urandom_range(0, a_gap_max);
                if (gap != 0) begin
                    a_valid = 1'b0;
                    repeat (gap) begin @(posedge clk); #1; end
                end
                a_valid = 1'b1;
                a_data  = item;
                do @(negedge clk); while (!a_ready && !flush);
                @(posedge clk); #1;
            end
        end
    end

    initial begin : drv_b
        logic [DW-1:0] item;
        int unsigned   gap;
        b_valid = 1'b0;
        b_data  = '0;
        forever begin
            if (b_q.size() == 0 || flush) begin
                b_valid = 1'b0;
                @(posedge clk); #1;
            end else begin
                item = b_q.pop_front();
                gap  = $urandom_range(0, b_gap_max);
                if (gap != 0) begin
                    b_valid = 1'b0;
                    repeat (gap) begin @(posedge clk); #1; end
                end
                if (b_lag != 0) begin
                    b_valid = 1'b0;
                    do begin @(posedge clk); #1; end while (!a_valid && !flush);
                    repeat (b_lag - 1) begin @(posedge clk); #1; end
                end
                b_valid = 1'b1;
                b_data  = item;
                do @(negedge clk); while (!b_ready && !flush);
                @(posedge clk); #1;
            end
        end
    end

    initial begin : drv_res_ready
        res_ready = 1'b0;
        forever begin
            @(posedge clk); #2;
            case (rr_mode)
                0:       res_ready = 1'b0;
                1:       res_ready = 1'b1;
                default: res_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: protocol rules every cycle, scoreboard pop on each accepted result.
    initial begin : monitor
        logic          prev_fire = 1'b0, prev_rv = 1'b0, prev_stall = 1'b0;
        logic [DW-1:0] last_a = '0, last_b = '0, prev_ain = '0, prev_bin = '0;
        logic [AW-1:0] prev_rd = '0;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_outputs", {busy, a_ready, b_ready, mac_clr, mac_en, res_valid, mac_ain, mac_bin}, 0);
                prev_fire = 1'b0; prev_rv = 1'b0; prev_stall = 1'b0;
                prev_ain = '0; prev_bin = '0; fires = 0;
            end else begin
                check("en_after_fire", mac_en, prev_fire);
                if (prev_fire) begin
                    check("ain_capture", mac_ain, last_a);
                    check("bin_capture", mac_bin, last_b);
                end else begin
                    check("ain_hold", mac_ain, prev_ain);
                    check("bin_hold", mac_bin, prev_bin);
                end
                check("ready_joint", a_ready, b_ready);
                if (a_ready) check("ready_needs_valids", a_valid & b_valid, 1);
                if (prev_stall) begin
                    check("res_hold_valid", res_valid, 1);
                    check("res_hold_data", res_data, prev_rd);
                end
                if (mac_clr) begin
                    fires   = 0;
                    clr_cyc = cyc;
                end
                if (a_ready && a_valid) begin
                    fires++;
                    last_fire_cyc = cyc;
                    last_a = a_data;
                    last_b = b_data;
                end
                if (res_valid && !prev_rv) begin
                    if (exp_q.size() == 0) begin
                        compared++; mismatched++;
                        $display("FAIL res_unexpected: actual res_valid=1 data %0d required no result", res_data);
                    end else if (exp_q[0].len == 0) begin
                        check("empty_latency", cyc - clr_cyc, 1);
                    end else begin
                        check("last_fire_latency", cyc - last_fire_cyc, 2);
                    end
                end
                if (res_valid && res_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("res_data", res_data, e.sum);
                    check("pairs_consumed", fires, e.len);
                    $display("result len=%0d data=%0d expected=%0d", e.len, res_data, e.sum);
                    results_seen++;
                end
                prev_fire  = a_ready && a_valid;
                prev_rv    = res_valid;
                prev_stall = res_valid && !res_ready;
                prev_rd    = res_data;
                prev_ain   = mac_ain;
                prev_bin   = mac_bin;
            end
        end
    end

    task automatic push_job(input int unsigned n);
        exp_t        e;
        logic [63:0] s = '0;
        for (int i = 0; i < int'(n); i++) begin
            s += 64'(job_a[i]) * 64'(job_b[i]);
            a_q.push_back(job_a[i]);
            b_q.push_back(job_b[i]);
        end
        e.len = n;
        e.sum = s[AW-1:0];
        exp_q.push_back(e);
        jobs_issued++;
        @(posedge clk); #1;
        start = 1'b1;
        len   = n[LW-1:0];
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("clear_pulse", mac_clr, 1);
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (results_seen != jobs_issued && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("result_arrived", results_seen, jobs_issued);
        @(posedge clk); #1;
    endtask

    task automatic set_pairs(input int unsigned a0, b0, a1, b1, a2, b2, input int n);
        job_a.delete(); job_b.delete();
        if (n > 0) begin job_a.push_back(a0[DW-1:0]); job_b.push_back(b0[DW-1:0]); end
        if (n > 1) begin job_a.push_back(a1[DW-1:0]); job_b.push_back(b1[DW-1:0]); end
        if (n > 2) begin job_a.push_back(a2[DW-1:0]); job_b.push_back(b2[DW-1:0]); end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: actual no finish required finish within 100000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int i;
        rst = 1'b1; start = 1'b0; len = '0;
`ifdef MAC_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        rr_mode = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Back-to-back: continuously valid streams.
        set_pairs(1, 2, 3, 4, 5, 6, 3);
        push_job(3);
        wait_done(200);

        // Empty job.
        push_job(0);
        wait_done(50);

        // Misaligned streams: B trails A by 3 cycles per pair.
        b_lag = 3;
        set_pairs(10, 10, 2, 3, 0, 0, 2);
        push_job(2);
        wait_done(200);
        b_lag = 0;

        // Result backpressure with an ignored start.
        rr_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        set_pairs(255, 255, 0, 0, 0, 0, 1);
        push_job(1);
        i = 0;
        while (!res_valid && i < 30) begin @(negedge clk); i++; end
        check("bp_reached_done", res_valid, 1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            start = (k == 1);
            len   = 8'd9;
            @(negedge clk);
            check("bp_valid", res_valid, 1);
            check("bp_data", res_data, 65025);
            check("bp_busy", busy, 1);
        end
        @(posedge clk); #1;
        start   = 1'b0;
        rr_mode = 1;
        wait_done(30);
        @(negedge clk);
        check("idle_after_result", busy, 0);
        @(negedge clk);
        check("start_in_done_ignored", busy, 0);
        @(posedge clk); #1;

        // Reset in the middle of a 4-pair job.
        set_pairs(9, 9, 9, 9, 9, 9, 3);
        job_a.push_back(8'd9); job_b.push_back(8'd9);
        push_job(4);
        i = 0;
        while (fires < 2 && i < 50) begin @(negedge clk); i++; end
        check("mid_job_two_fires", fires, 2);
        @(posedge clk); #1;
        rst = 1'b1;
        flush = 1'b1;
        a_q.delete(); b_q.delete();
        void'(exp_q.pop_back());
        jobs_issued--;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        set_pairs(7, 7, 0, 0, 0, 0, 1);
        push_job(1);
        wait_done(50);

`ifdef MAC_SEQ_ABORT_EN
        // Abort after 1 of 3 pairs; no result may appear.
        a_q.push_back(8'd4); b_q.push_back(8'd5);
        @(posedge clk); #1;
        start = 1'b1; len = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        i = 0;
        while (fires < 1 && i < 20) begin @(negedge clk); i++; end
        check("abort_first_fire", fires, 1);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_clr_pulse", mac_clr, 1);
        @(negedge clk);
        check("abort_idle", busy, 0);
        check("abort_clr_once", mac_clr, 0);
        repeat (4) begin
            @(negedge clk);
            check("abort_no_result", res_valid, 0);
        end
        @(posedge clk); #1;
        set_pairs(3, 3, 0, 0, 0, 0, 1);
        push_job(1);
        wait_done(50);
`endif

        // Randomised jobs with random stream gaps and result backpressure.
        rr_mode = 2;
        for (int j = 0; j < 40; j++) begin
            int unsigned n;
            n = (j == 20) ? 255 : $urandom_range(0, 12);
            job_a.delete(); job_b.delete();
            for (int k = 0; k < int'(n); k++) begin
                job_a.push_back((j == 20) ? 8'hFF : 8'($urandom));
                job_b.push_back((j == 20) ? 8'hFF : 8'($urandom));
            end
            a_gap_max = $urandom_range(0, 3);
            b_gap_max = $urandom_range(0, 3);
            push_job(n);
            wait_done(5000);
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
